// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered CHANNELS:1 multiplexer of WIDTH-bit words.
// Manual mode selects the channel from sel. Auto-scan mode steps an internal
// index through the channels and dwells DWELL enabled cycles on each one.
// dout, ch, valid, wrap and sel_err are all registered.
// Optional feature macro: MUX_SCAN_MASK_EN adds a per-channel skip mask that
// applies to scan mode only.
// wrap is raised on the first sample of a new sweep, which is the sample that
// presents the first channel again after the last one.
module mux_scan_sel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       mask,
`endif
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int                 DCNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0]  DW_LAST = DCNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]     CH_LIM  = (SEL_W + 1)'(CHANNELS);
`ifndef MUX_SCAN_MASK_EN
  localparam logic [SEL_W-1:0]   LAST_CH = SEL_W'(CHANNELS - 1);
`endif

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t              state_r;
  logic [SEL_W-1:0]    ch_q_r;
  logic [DCNT_W-1:0]   dwell_r;
  logic                wrap_pend_r;

  logic                entering_s;
  logic                live_s;
  logic [SEL_W-1:0]    base_ch_s;
  logic [DCNT_W-1:0]   base_dwell_s;
  logic                base_pend_s;
  logic [SEL_W-1:0]    succ_ch_s;
  logic                succ_cross_s;
  logic [SEL_W-1:0]    next_ch_s;
  logic [DCNT_W-1:0]   next_dwell_s;
  logic                next_pend_s;
  logic                sel_bad_s;
  logic [SEL_W-1:0]    sel_idx_s;
  logic [WIDTH-1:0]    man_word_s;
  logic [WIDTH-1:0]    scan_word_s;

`ifdef MUX_SCAN_MASK_EN
  logic                first_found_s;
  logic                first_cross_s;
  logic [SEL_W-1:0]    first_ch_s;
  logic                succ_found_s;

  // Nearest unmasked channel at or after cur (incl=1) or strictly after cur
  // (incl=0), searching circularly; result is {found, crossed_index_0, index}.
  function automatic logic [SEL_W+1:0] find_unmasked(
    input logic [SEL_W-1:0]    cur,
    input logic [CHANNELS-1:0] msk,
    input logic                incl
  );
    logic [SEL_W+1:0]    res;
    logic [CHANNELS-1:0] sh;
    int                  lo;
    int                  pos;
    res = '0;
    lo  = incl ? 0 : 1;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int off = CHANNELS; off >= 0; off--) begin
      pos = int'(cur) + off;
      if ((off >= lo) && (off < lo + CHANNELS)) begin
        if (pos >= CHANNELS) begin
          sh = msk >> (pos - CHANNELS);
          res = sh[0] ? res : {1'b1, 1'b1, SEL_W'(pos - CHANNELS)};
        end else begin
          sh = msk >> pos;
          res = sh[0] ? res : {1'b1, 1'b0, SEL_W'(pos)};
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction
`endif

  // Scan bookkeeping: effective index/dwell for this edge and their successors.
  always_comb begin
    entering_s = (state_r == MANUAL);
`ifdef MUX_SCAN_MASK_EN
    {first_found_s, first_cross_s, first_ch_s} = find_unmasked('0, mask, 1'b1);
    live_s = first_found_s;
`else
    live_s = 1'b1;
`endif
    if (entering_s) begin
`ifdef MUX_SCAN_MASK_EN
      base_ch_s   = first_ch_s;
      base_pend_s = first_cross_s;
`else
      base_ch_s   = '0;
      base_pend_s = 1'b0;
`endif
      base_dwell_s = '0;
    end else begin
      base_ch_s    = ch_q_r;
      base_dwell_s = dwell_r;
      base_pend_s  = wrap_pend_r;
    end
`ifdef MUX_SCAN_MASK_EN
    {succ_found_s, succ_cross_s, succ_ch_s} = find_unmasked(base_ch_s, mask, 1'b0);
`else
    succ_ch_s    = (base_ch_s == LAST_CH) ? '0 : base_ch_s + SEL_W'(1);
    succ_cross_s = (base_ch_s == LAST_CH);
`endif
    if (base_dwell_s == DW_LAST) begin
`ifdef MUX_SCAN_MASK_EN
      next_ch_s   = succ_found_s ? succ_ch_s : base_ch_s;
`else
      next_ch_s   = succ_ch_s;
`endif
      next_dwell_s = '0;
      next_pend_s  = succ_cross_s;
    end else begin
      next_ch_s    = base_ch_s;
      next_dwell_s = base_dwell_s + DCNT_W'(1);
      next_pend_s  = 1'b0;
    end
  end

  // Word selection for both paths; an out-of-range manual select yields zero.
  always_comb begin
    sel_bad_s   = ({1'b0, sel} >= CH_LIM);
    sel_idx_s   = sel_bad_s ? '0 : sel;
    man_word_s  = sel_bad_s ? '0 : WIDTH'(din >> (int'(sel_idx_s) * WIDTH));
    scan_word_s = WIDTH'(din >> (int'(base_ch_s) * WIDTH));
  end

  // Mode FSM, scan index/dwell state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= MANUAL;
      ch_q_r      <= '0;
      dwell_r     <= '0;
      wrap_pend_r <= 1'b0;
      dout        <= '0;
      ch          <= '0;
      valid       <= 1'b0;
      wrap        <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state_r <= mode ? SCAN : MANUAL;
      case (mode)
        1'b0: begin
          ch_q_r      <= '0;
          dwell_r     <= '0;
          wrap_pend_r <= 1'b0;
          wrap        <= 1'b0;
          valid       <= en;
          if (en) begin
            dout    <= man_word_s;
            ch      <= sel;
            sel_err <= sel_bad_s;
          end
        end
        1'b1: begin
          if (en && live_s) begin
            dout        <= scan_word_s;
            ch          <= base_ch_s;
            valid       <= 1'b1;
            wrap        <= base_pend_s;
            ch_q_r      <= next_ch_s;
            dwell_r     <= next_dwell_s;
            wrap_pend_r <= next_pend_s;
          end else begin
            valid       <= 1'b0;
            wrap        <= 1'b0;
            ch_q_r      <= base_ch_s;
            dwell_r     <= base_dwell_s;
            wrap_pend_r <= base_pend_s;
          end
        end
        default: begin
          valid <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel: the stimulus side pushes expected samples
// computed from a position-based scan model; a monitor pops them on valid.
module tb_mux_scan_sel;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 6;
  localparam int SEL_W    = 3;
  localparam int DWELL    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          ch;
  logic                      valid;
  logic                      wrap;
  logic                      sel_err;
`ifdef MUX_SCAN_MASK_EN
  logic [CHANNELS-1:0]       mask = '0;
`endif

  mux_scan_sel #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask),
`endif
    .dout(dout), .ch(ch), .valid(valid), .wrap(wrap), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] dout;
    logic [SEL_W-1:0] ch;
    logic             wrap;
    logic             sel_err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: number of enabled scan samples since scan start.
  int   m_pos;
  logic m_prev_mode;
  logic m_sel_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge and queue the expected sample.
  task automatic drive(input logic m, input logic e, input logic [SEL_W-1:0] s, input bit fixed);
    exp_t x;
    @(negedge clk);
    mode = m;
    en   = e;
    sel  = s;
    for (int k = 0; k < CHANNELS; k++)
      din[k*WIDTH +: WIDTH] = fixed ? WIDTH'(8'h10 + k) : WIDTH'($urandom);
    if (m && !m_prev_mode) m_pos = 0;
    if (e) begin
      if (m) begin
        x.ch      = SEL_W'((m_pos / DWELL) % CHANNELS);
        x.dout    = WIDTH'(din >> (int'(x.ch) * WIDTH));
        x.wrap    = (m_pos != 0) && ((m_pos % (CHANNELS * DWELL)) == 0);
        x.sel_err = m_sel_err;
        m_pos++;
      end else begin
        m_sel_err = (int'(s) >= CHANNELS);
        x.ch      = s;
        x.dout    = m_sel_err ? '0 : WIDTH'(din >> (int'(s) * WIDTH));
        x.wrap    = 1'b0;
        x.sel_err = m_sel_err;
      end
      exp_q.push_back(x);
    end
    m_prev_mode = m;
  endtask

  // Monitor: compare every presented sample against the head of the queue.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got ch=%0d dout=%0h expected no sample", ch, dout);
        end else begin
          mon_x = exp_q.pop_front();
          check("dout", 32'(dout), 32'(mon_x.dout));
          check("ch", 32'(ch), 32'(mon_x.ch));
          check("wrap", 32'(wrap), 32'(mon_x.wrap));
          check("sel_err", 32'(sel_err), 32'(mon_x.sel_err));
        end
      end else begin
        check("wrap_idle", 32'(wrap), 32'd0);
      end
    end
  end

  initial begin
    logic m;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    sel  = '0;
    din  = '0;
    m_pos = 0;
    m_prev_mode = 1'b0;
    m_sel_err = 1'b0;
    #12;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ch", 32'(ch), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Manual selection including out-of-range selects.
    drive(1'b0, 1'b1, 3'd3, 1'b1);
    drive(1'b0, 1'b1, 3'd5, 1'b1);
    drive(1'b0, 1'b1, 3'd6, 1'b1);
    drive(1'b0, 1'b0, 3'd1, 1'b1);
    drive(1'b0, 1'b1, 3'd7, 1'b1);
    drive(1'b0, 1'b1, 3'd2, 1'b1);

    // Continuous scan across more than a full sweep.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 3'd0, 1'b0);

    // Enable gating during scan.
    for (int i = 0; i < 24; i++) drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);

    // Random mix of modes, enables and selects.
    m = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) m = ~m;
      drive(m, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'b0);
    end

    // Reset in the middle of a scan with the internal index at channel 5.
    drive(1'b0, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_ch", 32'(ch), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_wrap", 32'(wrap), 32'd0);
    check("midrst_sel_err", 32'(sel_err), 32'd0);
    exp_q.delete();
    m_pos = 0;
    m_prev_mode = 1'b0;
    m_sel_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 3'd0, 1'b0);

    drive(1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
